product_accumulator: RTL

Sequential accumulator directly downstream of the n-bit array multiplier. It consumes a stream of 2n-bit unsigned products over a valid/ready handshake and sums a programmed number of them into a (2n+g)-bit result, which it presents on an output handshake together with a sticky overflow flag. It turns the combinational multiplier into the core of a dot-product / MAC datapath.

---
 rtl/product_accumulator_if.sv | 64 ++++++
 rtl/product_accumulator.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/product_accumulator_if.sv
// ---------------------------------------------------------------------------
// product_accumulator_if
//
// Purpose: bundles the command, product-stream and result handshakes of the
//          product_accumulator into one interface.
//
// Signals:
//   start      command   begin a new accumulation (honoured only when idle)
//   len        command   number of products to sum, sampled with start
//   busy       status    accumulator is not idle
//   p          stream    unsigned 2n-bit product from the multiplier
//   p_valid    stream    p carries a product
//   p_ready    stream    accumulator takes p this cycle
//   acc        result    accumulated (2n+g)-bit sum
//   acc_valid  result    acc and ovf are final
//   acc_ready  result    consumer takes the result this cycle
//   ovf        result    sticky carry-out flag of the current accumulation
//
// Modports:
//   master  producer/consumer side (drives commands, products, acc_ready)
//   slave   accumulator side
// ---------------------------------------------------------------------------
interface product_accumulator_if #(
    parameter int n  = 8,
    parameter int g  = 4,
    parameter int cw = 8
);
    logic                 start;
    logic [cw-1:0]        len;
    logic                 busy;
    logic [2*n-1:0]       p;
    logic                 p_valid;
    logic                 p_ready;
    logic [2*n+g-1:0]     acc;
    logic                 acc_valid;
    logic                 acc_ready;
    logic                 ovf;

    modport master (
        output start,
        output len,
        input  busy,
        output p,
        output p_valid,
        input  p_ready,
        input  acc,
        input  acc_valid,
        output acc_ready,
        input  ovf
    );

    modport slave (
        input  start,
        input  len,
        output busy,
        input  p,
        input  p_valid,
        output p_ready,
        output acc,
        output acc_valid,
        input  acc_ready,
        output ovf
    );
endinterface

// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
//
// Purpose: sums a programmed number of unsigned 2n-bit products, arriving
//          over a valid/ready stream, into a (2n+g)-bit accumulator and
//          presents the sum plus a sticky overflow flag on an output
//          handshake. Together with the upstream array multiplier it forms
//          the core of a MAC / dot-product datapath.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset; returns to IDLE and clears
//               acc, remaining count and ovf
//   bus    slave modport of product_accumulator_if (command, product stream,
//               result handshake)
//
// Configuration:
//   ACC_SAT_EN  when defined, a carry out of the accumulator saturates acc to
//               all ones; when undefined the sum wraps modulo 2^(2n+g).
//               ovf is set on a carry out in both builds.
//
// All outputs are decoded from registered state only; no input reaches an
// output combinationally.
// ---------------------------------------------------------------------------
module product_accumulator #(
    parameter int n  = 8,
    parameter int g  = 4,
    parameter int cw = 8
) (
    input logic                  clk,
    input logic                  reset,
    product_accumulator_if.slave bus
);

    localparam int AW = 2*n + g;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [AW-1:0]   r_acc;
    logic [cw-1:0]   r_rem;
    logic            r_ovf;

    logic            w_p_ready;
    logic            w_accept;
    logic            w_last;
    logic [AW:0]     w_sum;

    // Reduce the AW+1-bit raw sum to the stored accumulator value. The top
    // bit of the argument is the carry out of the accumulator.
    function automatic logic [AW-1:0] f_wrap_or_sat(input logic [AW:0] s);
`ifdef ACC_SAT_EN
        // Once saturated, acc stays at all ones: all-ones plus any non-zero
        // product carries again, and plus zero leaves it unchanged.
        return s[AW] ? {AW{1'b1}} : s[AW-1:0];
`else
        return s[AW-1:0];
`endif
    endfunction

    // Handshake decode from registered state
    assign w_p_ready = (r_state == S_ACC);
    assign w_accept  = w_p_ready && bus.p_valid;
    assign w_last    = (r_rem == cw'(1));

    // Sum computed one bit wider than the accumulator so the carry out is
    // visible; the product is zero-extended.
    assign w_sum = {1'b0, r_acc} + {{(g+1){1'b0}}, bus.p};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = (bus.len == '0) ? S_DONE : S_ACC;
                end
            end
            S_ACC: begin
                if (w_accept && w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // A new start cannot be taken here; IDLE is entered first.
                if (bus.acc_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Accumulator, remaining-count and overflow registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
            r_rem <= '0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_acc <= '0;
                        r_rem <= bus.len;
                        r_ovf <= 1'b0;
                    end
                end
                S_ACC: begin
                    if (w_accept) begin
                        r_acc <= f_wrap_or_sat(w_sum);
                        r_rem <= r_rem - cw'(1);
                        r_ovf <= r_ovf | w_sum[AW];
                    end
                end
                default: begin
                    // DONE holds acc and ovf stable until the handoff.
                end
            endcase
        end
    end

    // Outputs
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.p_ready   = w_p_ready;
    assign bus.acc_valid = (r_state == S_DONE);
    assign bus.acc       = r_acc;
    assign bus.ovf       = r_ovf;

endmodule
